farm_road_traffic_sim: RTL

Behavioural model of the farm-road side of the intersection, used as the far end of the traffic-light controller interface. It consumes the four one-hot light-phase signals and an external vehicle-arrival strobe, and maintains a saturating vehicle queue. It drains the queue only during farm-road green and drives the sensor signal back to the controller. It also checks the phase stream for protocol violations and raises a sticky fault, making the sensor-to-lights loop self-checking in simulation and on the FPGA.

---
 rtl/traffic_pkg.sv | 60 ++++++
 rtl/traffic_phase_checker.sv | 63 ++++++
 rtl/farm_road_traffic_sim.sv | 98 +++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the farm-road side of the traffic-light
// interface: the light-phase enumeration, a decoder from the four one-hot
// light bits to a phase, and the legal phase-successor function.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int DefaultQueueDepth     = 15;
    localparam int DefaultDepartInterval = 2;

    typedef enum logic [2:0] {
        PH_UNKNOWN,
        PH_HG,
        PH_HY,
        PH_FG,
        PH_FY
    } phase_t;

    // Decoded light vector: phase is only meaningful when oneHot is set.
    typedef struct packed {
        logic   oneHot;
        phase_t phase;
    } phaseDecode_t;

    function automatic phaseDecode_t decodePhase(
        input logic hg,
        input logic hy,
        input logic fg,
        input logic fy
    );
        phaseDecode_t d;
        d.oneHot = 1'b1;
        case ({hg, hy, fg, fy})
            4'b1000: d.phase = PH_HG;
            4'b0100: d.phase = PH_HY;
            4'b0010: d.phase = PH_FG;
            4'b0001: d.phase = PH_FY;
            default: begin
                d.oneHot = 1'b0;
                d.phase  = PH_UNKNOWN;
            end
        endcase
        return d;
    endfunction

    // The only phase a known phase may advance to (besides holding).
    function automatic phase_t legalSuccessor(input phase_t p);
        phase_t n;
        case (p)
            PH_HG:   n = PH_HY;
            PH_HY:   n = PH_FG;
            PH_FG:   n = PH_FY;
            PH_FY:   n = PH_HG;
            default: n = PH_UNKNOWN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_phase_checker.sv
// -----------------------------------------------------------------------------
// traffic_phase_checker
// Watches the four light-phase bits and raises a sticky fault on any
// protocol violation: an illegal phase move, an all-dark vector once the
// phase is known, or more than one phase bit lit.
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous, active-high
//   highW_G_farm_R_i    phase HG
//   highW_Y_farm_R_i    phase HY
//   highW_R_farm_G_i    phase FG
//   highW_R_farm_Y_i    phase FY
//   fault_o             sticky violation flag, cleared only by reset
// -----------------------------------------------------------------------------
module traffic_phase_checker
    import traffic_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic highW_G_farm_R_i,
    input  logic highW_Y_farm_R_i,
    input  logic highW_R_farm_G_i,
    input  logic highW_R_farm_Y_i,
    output logic fault_o
);

    phase_t       state;
    phaseDecode_t dec;
    logic         anyBit;

    assign dec    = decodePhase(highW_G_farm_R_i, highW_Y_farm_R_i,
                                highW_R_farm_G_i, highW_R_farm_Y_i);
    assign anyBit = |{highW_G_farm_R_i, highW_Y_farm_R_i,
                      highW_R_farm_G_i, highW_R_farm_Y_i};

    // NOTE: state and fault_o are registers, so every assignment here is
    // non-blocking; blocking ones would let later reads see this cycle's
    // update and race against other clocked blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= PH_UNKNOWN;
            fault_o <= 1'b0;
        end else if (state == PH_UNKNOWN) begin
            // Dark lights are tolerated until the first clean phase appears.
            if (dec.oneHot) begin
                state <= dec.phase;
            end else if (anyBit) begin
                fault_o <= 1'b1;
            end
        end else if (dec.oneHot) begin
            // Follow the lights even on a bad move so one glitch is not
            // reported as a cascade of further violations.
            state <= dec.phase;
            if (dec.phase != state && dec.phase != legalSuccessor(state)) begin
                fault_o <= 1'b1;
            end
        end else begin
            fault_o <= 1'b1;
        end
    end

endmodule

// File: rtl/farm_road_traffic_sim.sv
// -----------------------------------------------------------------------------
// farm_road_traffic_sim
// Behavioural model of the farm road: a saturating vehicle queue fed by an
// arrival strobe and drained one vehicle every DEPART_INTERVAL cycles of
// farm-road green. The non-empty queue drives the controller's sensor, and
// a phase checker flags protocol violations on the light outputs.
// QUEUE_DEPTH and DEPART_INTERVAL must both be at least 1.
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous, active-high
//   arrival_i           one vehicle arrives per cycle asserted
//   highW_*_farm_*_i    one-hot light phase from the controller
//   sensor_o            vehicle waiting (combinational from the count register)
//   queue_count_o       current queue occupancy
//   depart_o            one-cycle pulse per departing vehicle
//   drop_o              one-cycle pulse per arrival lost to a full queue
//   fault_o             sticky phase-protocol violation
// -----------------------------------------------------------------------------
module farm_road_traffic_sim
    import traffic_pkg::*;
#(
    parameter int QUEUE_DEPTH     = DefaultQueueDepth,
    parameter int DEPART_INTERVAL = DefaultDepartInterval
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             arrival_i,
    input  logic                             highW_G_farm_R_i,
    input  logic                             highW_Y_farm_R_i,
    input  logic                             highW_R_farm_G_i,
    input  logic                             highW_R_farm_Y_i,
    output logic                             sensor_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count_o,
    output logic                             depart_o,
    output logic                             drop_o,
    output logic                             fault_o
);

    localparam int CountW = $clog2(QUEUE_DEPTH + 1);
    localparam int DcntW  = (DEPART_INTERVAL > 1) ? $clog2(DEPART_INTERVAL) : 1;

    localparam logic [CountW-1:0] CountMax = CountW'(QUEUE_DEPTH);
    localparam logic [DcntW-1:0]  DcntLast = DcntW'(DEPART_INTERVAL - 1);

    logic [DcntW-1:0] dcnt;
    logic             queueEmpty;
    logic             departNow;

    assign queueEmpty = (queue_count_o == '0);
    assign sensor_o   = !queueEmpty;
    assign departNow  = highW_R_farm_G_i && !queueEmpty && (dcnt == DcntLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            queue_count_o <= '0;
            dcnt          <= '0;
            depart_o      <= 1'b0;
            drop_o        <= 1'b0;
        end else begin
            depart_o <= departNow;
            drop_o   <= 1'b0;

            // Progress toward a departure is lost whenever green ends or
            // the queue runs dry, so each vehicle waits a full interval.
            if (!highW_R_farm_G_i || queueEmpty || departNow) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DcntW'(1);
            end

            // A simultaneous arrival and departure leaves the count as-is,
            // which is why a full queue does not drop in that cycle.
            if (arrival_i && !departNow) begin
                if (queue_count_o < CountMax) begin
                    queue_count_o <= queue_count_o + CountW'(1);
                end else begin
                    drop_o <= 1'b1;
                end
            end else if (departNow && !arrival_i) begin
                queue_count_o <= queue_count_o - CountW'(1);
            end
        end
    end

    // The checker only observes the lights; departures above ignore its
    // verdict and keep following farm green even after a fault.
    traffic_phase_checker u_checker (
        .clk              (clk),
        .reset            (reset),
        .highW_G_farm_R_i (highW_G_farm_R_i),
        .highW_Y_farm_R_i (highW_Y_farm_R_i),
        .highW_R_farm_G_i (highW_R_farm_G_i),
        .highW_R_farm_Y_i (highW_R_farm_Y_i),
        .fault_o          (fault_o)
    );

endmodule
